tdp_ram_arb: RTL and testbench
==============================

# tdp_ram_arb

Round-robin arbiter that shares one true dual-port RAM (two single-clock read/write ports, 1-cycle registered read) among NUM_REQ requesters. Each cycle it grants up to two requests, one to RAM port A and one to RAM port B. It suppresses same-address hazards between the two ports and returns read data to the issuing requester one cycle after grant. It sits between client engines and the shared RAM instance in the buffer subsystem.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM address width
- clk  in  1  single clock for all logic and both RAM ports
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (grant)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  NUM_REQ*DATA_WIDTH  packed read data; slice i meaningful only when rsp_valid[i]=1
- ram_ena, ram_wea  out  1 each  port A enable and write enable
- ram_addra  out  ADDR_WIDTH  port A address
- ram_dina  out  DATA_WIDTH  port A write data
- ram_douta  in  DATA_WIDTH  port A read data
- ram_enb, ram_web, ram_addrb, ram_dinb, ram_doutb  same as port A, for port B
- conflict_cnt  out  16  present only with TDP_RAM_ARB_CONFLICT_CNT_EN

## Operation
- Handshake: a request transfers when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid, the addresses, the write enables and rr_ptr. A requester holds its valid and payload stable until accepted. No response backpressure.
- Arbitration: scan requesters circularly starting at rr_ptr. The first valid requester (W0) gets port A.
- Port B goes to the next valid requester in scan order that is hazard-free against W0.
- Hazard rule: same address with at least one write. A read/read pair to the same address is allowed.
- Requesters skipped because of a hazard stay pending; they are not dropped.
- rr_ptr update: when at least one grant is issued, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds.
- RAM drive:
  - Granted port: en=1, we=req_we, addr and din taken from the winner.
  - Idle port: en=0, we=0, addr=0, din=0.
- Read return: for each port granted a read, register the requester index (port_a_id, port_b_id plus a valid bit).
  - Next cycle, assert rsp_valid[id] and drive slice id of rsp_rdata from that port's dout.
  - Slices with no response are driven 0.
  - Writes produce no response.
- A requester can hold at most one grant per cycle, so the two ports never deliver to the same requester in the same cycle.

## Timing
- Grant: same cycle as valid (0-cycle arbitration latency).
- Read latency: rsp_valid exactly 1 cycle after the accepting edge.
- Throughput: up to 2 accepts per cycle; 1 per requester per cycle.
- Reset values (rst high, asynchronous): rr_ptr=0, response registers cleared, rsp_valid=0, rsp_rdata=0, conflict_cnt=0.
  - While rst is high, req_ready=0 and all ram_en*/we* = 0.
- Reset asserted with a read in flight: the response is dropped; rsp_valid=0 in the following cycle.
- First cycle after rst deasserts: normal arbitration from rr_ptr=0.

## Configuration
- TDP_RAM_ARB_CONFLICT_CNT_EN defined:
  - Adds the conflict_cnt port, a 16-bit counter.
  - Increments by 1 in every cycle in which at least one valid requester was skipped due to the hazard rule.
  - Saturates at 0xFFFF; cleared by rst.
- Undefined: port and counter are absent; arbitration behaviour is identical.

## Test plan
- Reset check: rst pulse mid-read (req 0 read addr 0x010 granted, rst asserted next edge) -> rsp_valid stays 0; all outputs at reset values; rr_ptr=0 afterwards.
- Dual issue: req 0 write addr 0x005 data 0xA5A5_0001, req 2 write addr 0x006 data 0x5A5A_0002 in the same cycle -> both ready; port A=req 0, port B=req 2. Next cycle, req 1 reads 0x005 and req 3 reads 0x006 -> one cycle later rsp_valid=4'b1010 with data 0xA5A5_0001 and 0x5A5A_0002.
- Hazard: req 0 write 0x020, req 1 read 0x020, req 2 read 0x030, rr_ptr=0 -> grants req 0 (A) and req 2 (B); req 1 granted the next cycle and reads the new value; conflict_cnt=1 when enabled.
- Read/read same address: req 1 and req 3 both read 0x040 -> both granted the same cycle; identical rdata on both slices next cycle.
- Fairness: all four requesters hold reads continuously for 8 cycles -> grant pairs (0,1),(2,3),(0,1)… with each requester accepting exactly 4 times.
- Saturation (macro on): force a hazard every cycle for 70000 cycles -> conflict_cnt stops at 0xFFFF.

Source files
------------

// File: rtl/tdp_ram_arb.sv
// Round-robin arbiter sharing one true dual-port RAM among NUM_REQ requesters.
// Optional hazard-skip counter port enabled by TDP_RAM_ARB_CONFLICT_CNT_EN.
module tdp_ram_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
  output logic                             ram_ena,
  output logic                             ram_wea,
  output logic [ADDR_WIDTH-1:0]            ram_addra,
  output logic [DATA_WIDTH-1:0]            ram_dina,
  input  logic [DATA_WIDTH-1:0]            ram_douta,
  output logic                             ram_enb,
  output logic                             ram_web,
  output logic [ADDR_WIDTH-1:0]            ram_addrb,
  output logic [DATA_WIDTH-1:0]            ram_dinb,
  input  logic [DATA_WIDTH-1:0]            ram_doutb
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                      conflict_cnt
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDW-1:0] id_t;

  logic [ADDR_WIDTH-1:0] addr_s  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] rdata_s [NUM_REQ];
  id_t                   scan_idx_s [NUM_REQ];

  id_t  rr_ptr_q, rr_ptr_d;
  logic a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  id_t  a_id_q, a_id_d, b_id_q, b_id_d;

  logic grant_a_s, grant_b_s, skip_s;
  id_t  w0_s, w1_s;

  function automatic id_t wrap_idx(input id_t base, input int offs);
    int j;
    j = int'(base) + offs;
    if (j >= NUM_REQ) begin
      j = j - NUM_REQ;
    end else begin
      j = j;
    end
    return id_t'(j);
  endfunction

  // Same address with at least one write may not share a cycle across ports.
  function automatic logic hazard(input logic [ADDR_WIDTH-1:0] addr0, input logic we0,
                                  input logic [ADDR_WIDTH-1:0] addr1, input logic we1);
    return (addr0 == addr1) && (we0 || we1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_s[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_s[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rdata_s[g];
  end

  // Circular scan order starting at the round-robin pointer.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s[k] = wrap_idx(rr_ptr_q, k);
    end
  end

  // Pick W0 for port A, then the first hazard-free follower for port B.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    skip_s    = 1'b0;
    w0_s      = '0;
    w1_s      = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[scan_idx_s[k]]) begin
          if (!grant_a_s) begin
            grant_a_s = 1'b1;
            w0_s      = scan_idx_s[k];
          end else if (!grant_b_s) begin
            if (hazard(addr_s[scan_idx_s[k]], req_we[scan_idx_s[k]], addr_s[w0_s], req_we[w0_s])) begin
              skip_s = 1'b1;
            end else begin
              grant_b_s = 1'b1;
              w1_s      = scan_idx_s[k];
            end
          end else begin
            grant_b_s = grant_b_s;
          end
        end else begin
          grant_a_s = grant_a_s;
        end
      end
    end else begin
      grant_a_s = 1'b0;
    end
  end

  // Grant vector and RAM port drive; idle ports are fully zeroed.
  always_comb begin
    req_ready = '0;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    ram_enb   = 1'b0;
    ram_web   = 1'b0;
    ram_addrb = '0;
    ram_dinb  = '0;
    if (grant_a_s) begin
      req_ready[w0_s] = 1'b1;
      ram_ena         = 1'b1;
      ram_wea         = req_we[w0_s];
      ram_addra       = addr_s[w0_s];
      ram_dina        = wdata_s[w0_s];
    end else begin
      ram_ena = 1'b0;
    end
    if (grant_b_s) begin
      req_ready[w1_s] = 1'b1;
      ram_enb         = 1'b1;
      ram_web         = req_we[w1_s];
      ram_addrb       = addr_s[w1_s];
      ram_dinb        = wdata_s[w1_s];
    end else begin
      ram_enb = 1'b0;
    end
  end

  // Next pointer follows the last granted requester; read ids are tracked per port.
  always_comb begin
    a_vld_d = grant_a_s && !req_we[w0_s];
    a_id_d  = w0_s;
    b_vld_d = grant_b_s && !req_we[w1_s];
    b_id_d  = w1_s;
    if (grant_b_s) begin
      rr_ptr_d = wrap_idx(w1_s, 1);
    end else if (grant_a_s) begin
      rr_ptr_d = wrap_idx(w0_s, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer and in-flight read bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      a_vld_q  <= 1'b0;
      a_id_q   <= '0;
      b_vld_q  <= 1'b0;
      b_id_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      a_vld_q  <= a_vld_d;
      a_id_q   <= a_id_d;
      b_vld_q  <= b_vld_d;
      b_id_q   <= b_id_d;
    end
  end

  // Route each port's registered read data to the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdata_s[i] = '0;
    end
    if (a_vld_q) begin
      rsp_valid[a_id_q] = 1'b1;
      rdata_s[a_id_q]   = ram_douta;
    end else begin
      rsp_valid = rsp_valid;
    end
    if (b_vld_q) begin
      rsp_valid[b_id_q] = 1'b1;
      rdata_s[b_id_q]   = ram_doutb;
    end else begin
      rsp_valid = rsp_valid;
    end
  end

`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  // Saturating count of cycles in which a valid requester lost out to a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
    end else if (skip_s && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_q <= conflict_cnt_q;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  logic unused_skip_s;
  assign unused_skip_s = skip_s;
`endif

endmodule

// File: tb/tb_tdp_ram_arb.sv
// Directed scenarios for tdp_ram_arb with a behavioural dual-port RAM and a read-response scoreboard.
module tb_tdp_ram_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_data [N];
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = t_addr[i];
      req_wdata[i*DW +: DW] = t_data[i];
    end
  end

  tdp_ram_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb),
    .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural true dual-port RAM, one-cycle registered read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ram_douta <= '0;
      ram_doutb <= '0;
    end else begin
      if (ram_ena) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        ram_douta <= mem[ram_addra];
      end
      if (ram_enb) begin
        if (ram_web) mem[ram_addrb] <= ram_dinb;
        ram_doutb <= mem[ram_addrb];
      end
    end
  end

  // Response monitor: pops entries due this cycle and compares every slice.
  initial begin
    logic [N-1:0]    exp_v;
    logic [N*DW-1:0] exp_d;
    sb_t             e;
    forever begin
      @(posedge clk);
      cyc_cnt = cyc_cnt + 1;
      #1;
      exp_v = '0;
      exp_d = '0;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
        e = sb_q.pop_front();
        exp_v[e.id] = 1'b1;
        exp_d[e.id*DW +: DW] = e.data;
      end
      n_checks++;
      if (rsp_valid !== exp_v) begin
        n_errs++;
        $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc_cnt, rsp_valid, exp_v);
      end
      n_checks++;
      if (rsp_rdata !== exp_d) begin
        n_errs++;
        $display("FAIL sb_rsp_rdata cyc=%0d got=%h exp=%h", cyc_cnt, rsp_rdata, exp_d);
      end
    end
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    t_addr[i]    = a;
    t_data[i]    = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      t_addr[i]    = '0;
      t_data[i]    = '0;
    end
  endtask

  task automatic push_rd(input int i);
    sb_t e;
    e.cyc  = cyc_cnt + 1;
    e.id   = i;
    e.data = ref_mem[t_addr[i]];
    sb_q.push_back(e);
  endtask

  task automatic do_wr(input int i);
    ref_mem[t_addr[i]] = t_data[i];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_req(0, 1'b0, 10'h010, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errs++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    n_checks++;
    if ({ram_ena, ram_wea, ram_enb, ram_web} !== 4'b0000) begin
      n_errs++; $display("FAIL rst_ram_en got=%b exp=0000", {ram_ena, ram_wea, ram_enb, ram_web});
    end
    n_checks++;
    if (rsp_valid !== 4'b0000 || rsp_rdata !== '0) begin
      n_errs++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_rdata);
    end
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd0) begin n_errs++; $display("FAIL rst_cnt got=%h exp=0", conflict_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001 || ram_ena !== 1'b1 || ram_addra !== 10'h010) begin
      n_errs++; $display("FAIL rst_first_grant got=%b/%b/%h exp=0001/1/010", req_ready, ram_ena, ram_addra);
    end
    @(posedge clk);
    rst = 1'b1;
    clr_all();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errs++; $display("FAIL rst_drop_rsp got=%b exp=0000", rsp_valid); end
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 10'h100, 32'h0);
    set_req(1, 1'b0, 10'h101, 32'h0);
    set_req(2, 1'b0, 10'h102, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0011 || ram_addra !== 10'h100 || ram_addrb !== 10'h101) begin
      n_errs++; $display("FAIL rst_ptr_zero got=%b/%h/%h exp=0011/100/101", req_ready, ram_addra, ram_addrb);
    end
    push_rd(0);
    push_rd(1);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100 || ram_addra !== 10'h102 || ram_enb !== 1'b0) begin
      n_errs++; $display("FAIL rst_pending got=%b/%h/%b exp=0100/102/0", req_ready, ram_addra, ram_enb);
    end
    push_rd(2);
    tick();
    clr_all();
  endtask

  task automatic test_dual_issue();
    set_req(0, 1'b1, 10'h005, 32'hA5A5_0001);
    set_req(2, 1'b1, 10'h006, 32'h5A5A_0002);
    #1;
    n_checks++;
    if (req_ready !== 4'b0101) begin n_errs++; $display("FAIL dual_ready got=%b exp=0101", req_ready); end
    n_checks++;
    if ({ram_ena, ram_wea, ram_addra, ram_dina} !== {1'b1, 1'b1, 10'h005, 32'hA5A5_0001}) begin
      n_errs++; $display("FAIL dual_port_a got=%b%b %h %h", ram_ena, ram_wea, ram_addra, ram_dina);
    end
    n_checks++;
    if ({ram_enb, ram_web, ram_addrb, ram_dinb} !== {1'b1, 1'b1, 10'h006, 32'h5A5A_0002}) begin
      n_errs++; $display("FAIL dual_port_b got=%b%b %h %h", ram_enb, ram_web, ram_addrb, ram_dinb);
    end
    do_wr(0);
    do_wr(2);
    tick();
    clr_all();
    set_req(1, 1'b0, 10'h005, 32'h0);
    set_req(3, 1'b0, 10'h006, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b1010 || ram_addra !== 10'h006 || ram_addrb !== 10'h005) begin
      n_errs++; $display("FAIL dual_read_grant got=%b/%h/%h exp=1010/006/005", req_ready, ram_addra, ram_addrb);
    end
    push_rd(1);
    push_rd(3);
    tick();
    clr_all();
    n_checks++;
    if (rsp_valid !== 4'b1010 || rsp_rdata[1*DW +: DW] !== 32'hA5A5_0001 || rsp_rdata[3*DW +: DW] !== 32'h5A5A_0002) begin
      n_errs++; $display("FAIL dual_rsp got=%b %h", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_hazard();
    set_req(3, 1'b0, 10'h000, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_errs++; $display("FAIL haz_prep got=%b exp=1000", req_ready); end
    push_rd(3);
    tick();
    clr_all();
    set_req(0, 1'b1, 10'h020, 32'hCAFE_0020);
    set_req(1, 1'b0, 10'h020, 32'h0);
    set_req(2, 1'b0, 10'h030, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0101 || ram_addra !== 10'h020 || ram_wea !== 1'b1 || ram_addrb !== 10'h030 || ram_web !== 1'b0) begin
      n_errs++; $display("FAIL haz_grant got=%b a=%h/%b b=%h/%b", req_ready, ram_addra, ram_wea, ram_addrb, ram_web);
    end
    do_wr(0);
    push_rd(2);
    tick();
    req_valid[0] = 1'b0;
    req_valid[2] = 1'b0;
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd1) begin n_errs++; $display("FAIL haz_cnt got=%0d exp=1", conflict_cnt); end
`endif
    #1;
    n_checks++;
    if (req_ready !== 4'b0010 || ram_addra !== 10'h020) begin
      n_errs++; $display("FAIL haz_retry got=%b/%h exp=0010/020", req_ready, ram_addra);
    end
    push_rd(1);
    tick();
    clr_all();
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_rdata[1*DW +: DW] !== 32'hCAFE_0020) begin
      n_errs++; $display("FAIL haz_newval got=%b %h exp=0010 cafe0020", rsp_valid, rsp_rdata[1*DW +: DW]);
    end
  endtask

  task automatic test_read_read();
    set_req(0, 1'b1, 10'h040, 32'h1234_5678);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errs++; $display("FAIL rr_prep got=%b exp=0001", req_ready); end
    do_wr(0);
    tick();
    clr_all();
    set_req(1, 1'b0, 10'h040, 32'h0);
    set_req(3, 1'b0, 10'h040, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b1010) begin n_errs++; $display("FAIL rr_grant got=%b exp=1010", req_ready); end
    push_rd(1);
    push_rd(3);
    tick();
    clr_all();
    n_checks++;
    if (rsp_rdata[1*DW +: DW] !== 32'h1234_5678 || rsp_rdata[3*DW +: DW] !== 32'h1234_5678) begin
      n_errs++; $display("FAIL rr_data got=%h/%h exp=12345678", rsp_rdata[1*DW +: DW], rsp_rdata[3*DW +: DW]);
    end
  endtask

  task automatic test_fairness();
    int          acc [N];
    logic [N-1:0] exp_r;
    for (int i = 0; i < N; i++) acc[i] = 0;
    set_req(0, 1'b0, 10'h005, 32'h0);
    set_req(1, 1'b0, 10'h006, 32'h0);
    set_req(2, 1'b0, 10'h020, 32'h0);
    set_req(3, 1'b0, 10'h040, 32'h0);
    for (int c = 0; c < 8; c++) begin
      exp_r = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      n_checks++;
      if (req_ready !== exp_r) begin n_errs++; $display("FAIL fair_cycle%0d got=%b exp=%b", c, req_ready, exp_r); end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) acc[i]++;
        if (exp_r[i]) push_rd(i);
      end
      tick();
    end
    clr_all();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (acc[i] !== 4) begin n_errs++; $display("FAIL fair_count req%0d got=%0d exp=4", i, acc[i]); end
    end
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd1) begin n_errs++; $display("FAIL fair_cnt got=%0d exp=1", conflict_cnt); end
`endif
  endtask

`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
  task automatic test_saturation();
    set_req(0, 1'b1, 10'h300, 32'h0000_0300);
    set_req(1, 1'b1, 10'h300, 32'h0001_0300);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin n_errs++; $display("FAIL sat_cnt got=%h exp=ffff", conflict_cnt); end
    clr_all();
    tick();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin n_errs++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    clr_all();
    @(negedge clk);
    test_reset();
    test_dual_issue();
    test_hazard();
    test_read_read();
    test_fairness();
`ifdef TDP_RAM_ARB_CONFLICT_CNT_EN
    test_saturation();
`endif
    tick();
    tick();
    n_checks++;
    if (sb_q.size() !== 0) begin n_errs++; $display("FAIL sb_drain got=%0d exp=0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
